// File: rtl/fifo_queue.sv
// rtl/fifo_queue.sv - synchronous FIFO (2^depth x width) with pointer-based full/empty tracking.
// Optional sticky overflow/underflow outputs enabled by FIFO_QUEUE_ERR_FLAGS_EN.

module fifo_queue_ram #(
    parameter int depth = 5,
    parameter int width = 4
) (
    input  logic             clk,
    input  logic             we,
    input  logic [depth-1:0] waddr,
    input  logic [width-1:0] wdata,
    input  logic [depth-1:0] raddr,
    output logic [width-1:0] rdata
);
    logic [width-1:0] mem [2**depth];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];
endmodule

module fifo_queue #(
    parameter int depth = 5,
    parameter int width = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic [width-1:0] pushedValue,
    output logic             empty,
    output logic             full,
    output logic [width-1:0] poppedValue
`ifdef FIFO_QUEUE_ERR_FLAGS_EN
    ,
    output logic             overflow,
    output logic             underflow
`endif
);
    logic [depth:0]   write_addr;
    logic [depth:0]   read_addr;
    logic [depth:0]   write_addr_next;
    logic [depth:0]   read_addr_next;
    logic [width-1:0] read_data;
    logic             push_acc;
    logic             pop_acc;

    // A push into a full FIFO is allowed when a pop frees the slot on the same edge.
    assign pop_acc  = pop && !empty;
    assign push_acc = push && (!full || pop_acc);

    assign write_addr_next = write_addr + {{depth{1'b0}}, push_acc};
    assign read_addr_next  = read_addr + {{depth{1'b0}}, pop_acc};

    fifo_queue_ram #(
        .depth(depth),
        .width(width)
    ) u_ram (
        .clk  (clk),
        .we   (push_acc),
        .waddr(write_addr[depth-1:0]),
        .wdata(pushedValue),
        .raddr(read_addr[depth-1:0]),
        .rdata(read_data)
    );

    // Flags are derived from the next pointers so they change on the same edge as the pointers.
    always_ff @(posedge clk) begin
        if (!reset) begin
            write_addr  <= '0;
            read_addr   <= '0;
            empty       <= 1'b1;
            full        <= 1'b0;
            poppedValue <= '0;
        end else begin
            write_addr <= write_addr_next;
            read_addr  <= read_addr_next;
            empty      <= (write_addr_next == read_addr_next);
            full       <= (write_addr_next[depth-1:0] == read_addr_next[depth-1:0]) &&
                          (write_addr_next[depth] != read_addr_next[depth]);
            if (pop_acc) begin
                poppedValue <= read_data;
            end
        end
    end

`ifdef FIFO_QUEUE_ERR_FLAGS_EN
    always_ff @(posedge clk) begin
        if (!reset) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (push && !push_acc) begin
                overflow <= 1'b1;
            end
            if (pop && !pop_acc) begin
                underflow <= 1'b1;
            end
        end
    end
`endif
endmodule

// File: tb/tb_fifo_queue.sv
// tb/tb_fifo_queue.sv - scoreboard bench for fifo_queue; honours FIFO_QUEUE_ERR_FLAGS_EN.

module tb_fifo_queue;
    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       push = 1'b0;
    logic       pop = 1'b0;
    logic [3:0] pushed_value = 4'd0;
    logic       empty;
    logic       full;
    logic [3:0] popped_value;
`ifdef FIFO_QUEUE_ERR_FLAGS_EN
    logic       overflow;
    logic       underflow;
`endif

    fifo_queue #(
        .depth(5),
        .width(4)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .push       (push),
        .pop        (pop),
        .pushedValue(pushed_value),
        .empty      (empty),
        .full       (full),
        .poppedValue(popped_value)
`ifdef FIFO_QUEUE_ERR_FLAGS_EN
        ,
        .overflow   (overflow),
        .underflow  (underflow)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       e_empty;
        logic       e_full;
        logic [3:0] e_pv;
        logic       e_ovf;
        logic       e_udf;
        int         tag;
    } exp_t;

    exp_t sb[$];
    exp_t mon_r;
    int   n_checks = 0;
    int   n_fail = 0;
    int   step_no = 0;
    logic exp_ovf = 1'b0;
    logic exp_udf = 1'b0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp, input int tag);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s step %0d: got %0h expected %0h", nm, tag, act, exp);
        end
    endtask

    // Drive one cycle; the hand-computed state expected after the edge goes to the scoreboard.
    task automatic cycle(input logic rst_n, input logic p, input logic [3:0] v, input logic q,
                         input logic e_empty, input logic e_full, input logic [3:0] e_pv, input bit chk);
        exp_t r;
        @(negedge clk);
        reset = rst_n;
        push = p;
        pushed_value = v;
        pop = q;
        @(posedge clk);
        if (chk) begin
            r.e_empty = e_empty;
            r.e_full = e_full;
            r.e_pv = e_pv;
            r.e_ovf = exp_ovf;
            r.e_udf = exp_udf;
            r.tag = step_no;
            sb.push_back(r);
        end
        step_no++;
    endtask

    always @(negedge clk) begin
        if (sb.size() > 0) begin
            mon_r = sb.pop_front();
            check("empty", 32'(empty), 32'(mon_r.e_empty), mon_r.tag);
            check("full", 32'(full), 32'(mon_r.e_full), mon_r.tag);
            check("popped_value", 32'(popped_value), 32'(mon_r.e_pv), mon_r.tag);
`ifdef FIFO_QUEUE_ERR_FLAGS_EN
            check("overflow", 32'(overflow), 32'(mon_r.e_ovf), mon_r.tag);
            check("underflow", 32'(underflow), 32'(mon_r.e_udf), mon_r.tag);
`endif
        end
    end

    initial begin
        logic       rp;
        logic       rq;
        logic [3:0] rv;

        // Reset with a push on the same edge: reset wins.
        cycle(1'b0, 1'b1, 4'd5, 1'b1, 1'b1, 1'b0, 4'd0, 1'b1);

        // Unchecked random activity, then reset must restore the idle state.
        for (int i = 0; i < 12; i++) begin
            rp = 1'($urandom_range(0, 1));
            rq = 1'($urandom_range(0, 1));
            rv = 4'($urandom_range(0, 15));
            cycle(1'b1, rp, rv, rq, 1'b0, 1'b0, 4'd0, 1'b0);
        end
        exp_ovf = 1'b0;
        exp_udf = 1'b0;
        cycle(1'b0, 1'b0, 4'd0, 1'b0, 1'b1, 1'b0, 4'd0, 1'b1);

        // Push 1..5 then pop 5.
        for (int i = 1; i <= 5; i++) begin
            cycle(1'b1, 1'b1, 4'(i), 1'b0, 1'b0, 1'b0, 4'd0, 1'b1);
        end
        for (int i = 1; i <= 5; i++) begin
            cycle(1'b1, 1'b0, 4'd0, 1'b1, (i == 5), 1'b0, 4'(i), 1'b1);
        end

        // Pop on empty is ignored.
        exp_udf = 1'b1;
        cycle(1'b1, 1'b0, 4'd0, 1'b1, 1'b1, 1'b0, 4'd5, 1'b1);

        // Fill to capacity, overflow attempt, drain; twice so the pointers wrap.
        for (int rep = 0; rep < 2; rep++) begin
            for (int i = 0; i < 32; i++) begin
                cycle(1'b1, 1'b1, 4'(i % 16), 1'b0, 1'b0, (i == 31), (rep == 0) ? 4'd5 : 4'd15, 1'b1);
            end
            exp_ovf = 1'b1;
            cycle(1'b1, 1'b1, 4'd9, 1'b0, 1'b0, 1'b1, (rep == 0) ? 4'd5 : 4'd15, 1'b1);
            for (int i = 0; i < 32; i++) begin
                cycle(1'b1, 1'b0, 4'd0, 1'b1, (i == 31), 1'b0, 4'(i % 16), 1'b1);
            end
        end

        // Simultaneous push/pop on full: oldest out, 7 stored last.
        for (int i = 0; i < 32; i++) begin
            cycle(1'b1, 1'b1, 4'(i % 16), 1'b0, 1'b0, (i == 31), 4'd15, 1'b1);
        end
        cycle(1'b1, 1'b1, 4'd7, 1'b1, 1'b0, 1'b1, 4'd0, 1'b1);
        for (int j = 0; j < 32; j++) begin
            cycle(1'b1, 1'b0, 4'd0, 1'b1, (j == 31), 1'b0, (j == 31) ? 4'd7 : 4'((j + 1) % 16), 1'b1);
        end

        // Simultaneous push/pop on empty: only the push lands.
        cycle(1'b1, 1'b1, 4'd3, 1'b1, 1'b0, 1'b0, 4'd7, 1'b1);
        cycle(1'b1, 1'b0, 4'd0, 1'b1, 1'b1, 1'b0, 4'd3, 1'b1);

        // Reset mid-operation discards queued entries.
        for (int i = 1; i <= 3; i++) begin
            cycle(1'b1, 1'b1, 4'(i), 1'b0, 1'b0, 1'b0, 4'd3, 1'b1);
        end
        exp_ovf = 1'b0;
        exp_udf = 1'b0;
        cycle(1'b0, 1'b1, 4'd4, 1'b0, 1'b1, 1'b0, 4'd0, 1'b1);
        exp_udf = 1'b1;
        cycle(1'b1, 1'b0, 4'd0, 1'b1, 1'b1, 1'b0, 4'd0, 1'b1);

        cycle(1'b1, 1'b0, 4'd0, 1'b0, 1'b1, 1'b0, 4'd0, 1'b0);
        for (int i = 0; i < 10 && sb.size() > 0; i++) begin
            @(posedge clk);
        end
        @(negedge clk);
        #1;
        if (sb.size() > 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/fifo_queue.md
# fifo_queue

Parameterized synchronous FIFO buffer built from a control unit (read/write pointers, full/empty tracking, output register) and a simple dual-port RAM of 2^depth words. It sits between a producer issuing `push` with `pushedValue` and a consumer issuing `pop` and reading `poppedValue`. Default sizing is 32 x 4 bits.

## Interface
- `depth`, default 5: address width; capacity = 2^depth entries (32).
- `width`, default 4: data word width in bits.

- `clk`  in  1: single clock; all state updates on rising edge.
- `reset`  in  1: one clock; reset is synchronous and active-low.
- `push`  in  1: write request; `pushedValue` sampled on the same edge.
- `pop`  in  1: read request.
- `pushedValue`  in  width: data to enqueue.
- `empty`  out  1: registered; 1 when the FIFO holds 0 entries.
- `full`  out  1: registered; 1 when the FIFO holds 2^depth entries.
- `poppedValue`  out  width: registered; value of the most recently accepted pop.

## Operation
- Storage: dual-port RAM, 2^depth x width, synchronous write, combinational read at `readAddr`. Contents are not cleared by reset.
- Pointers: `writeAddr` and `readAddr` are depth+1 bits. The low depth bits address the RAM. The MSB distinguishes full from empty.
- `empty` = pointers equal. `full` = low bits equal and MSBs differ.
- Pointers increment modulo 2^(depth+1) and wrap naturally.
- Push accepted when `push` and (not `full` or pop accepted):
  - RAM[writeAddr] <= `pushedValue`.
  - `writeAddr` increments.
- Pop accepted when `pop` and not `empty`:
  - `poppedValue` <= RAM[readAddr].
  - `readAddr` increments.
- Push while full without pop: ignored. No state change; data is dropped.
- Pop while empty: ignored. `poppedValue` holds its last value; pointers unchanged.
- Simultaneous push and pop:
  - Not empty and not full: both accepted; occupancy unchanged.
  - Full: both accepted. Oldest entry is output and new data is stored in the freed slot; `full` stays 1.
  - Empty: only the push is accepted; the pop is ignored.
- `poppedValue` holds between accepted pops.

## Timing
- Reset (`reset`=0 at a rising edge) clears pointers to 0: `empty`=1, `full`=0, `poppedValue`=0. Reset has priority over push/pop on that edge.
- Reset mid-operation discards all queued entries, effective the same edge.
- Write latency: data pushed at edge k is poppable at edge k+1. `empty` deasserts after edge k.
- Read latency: pop accepted at edge k; `poppedValue` is valid after edge k, i.e. one cycle after `pop` is asserted.
- Flags update on the same edge as the pointer change.
  - `full` asserts after the 2^depth-th net push.
  - `empty` asserts after the pop of the last entry.
- No combinational path from inputs to outputs.

## Configuration
- `FIFO_QUEUE_ERR_FLAGS_EN`: when defined, adds two outputs, `overflow` and `underflow` (1 bit each).
  - `overflow` is set by a rejected push.
  - `underflow` is set by a rejected pop.
  - Both are sticky until reset; reset value 0.
- When undefined, the ports and logic are absent. Core behaviour is identical either way.

## Test plan
- Hold `reset`=0 for one edge after random activity -> `empty`=1, `full`=0, `poppedValue`=0.
- Push 1,2,3,4,5 on consecutive cycles, then pop 5 cycles:
  - `empty`=0 after the first push; `full` never asserts.
  - `poppedValue` = 1,2,3,4,5 after each pop edge; `empty`=1 after the fifth pop.
- Pop once on empty after the previous scenario -> `poppedValue` stays 5, `empty` stays 1; `underflow`=1 if enabled.
- Push 32 values (i mod 16) -> `full`=1 after the 32nd.
  - A 33rd push (value 9) is ignored; `overflow`=1 if enabled.
  - Popping 32 times returns 0..15,0..15 in order.
  - Repeat once to exercise pointer wrap.
- Simultaneous push/pop:
  - On full with push 7: output is the oldest entry, `full` stays 1, and 7 is later popped last.
  - On empty with push 3: pop ignored, `poppedValue` unchanged, `empty`=0 next cycle.
- Push 3 entries, then `reset`=0 with `push`=1 on the same edge -> `empty`=1. A following pop is ignored and `poppedValue`=0.
